axi_read_arbiter: RTL
=====================

Name: axi_read_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the AXI read-address and read-data channels.
- Sits between the cache refill engines (i-cache, d-cache, prefetcher) and the single DRAM read port.
- Grants AR requests round-robin and tags the downstream ARID with the master index.
- Routes R beats back to the owning master by RID and enforces a per-master cap on outstanding bursts.

Parameters:
N_MASTERS, 2, number of upstream read masters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
MAX_OUTSTANDING, 4, maximum in-flight bursts per master (1..15)
IDX_W, $clog2(N_MASTERS) (min 1), master index width (derived, not overridable)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
m_arvalid  input  N_MASTERS  per-master AR valid
m_arready  output  N_MASTERS  per-master AR ready
m_araddr  input  N_MASTERS*ADDR_WIDTH  per-master address; master i occupies slice i
m_arlen  input  N_MASTERS*4  per-master burst length minus one
m_rvalid  output  N_MASTERS  per-master R valid
m_rready  input  N_MASTERS  per-master R ready
m_rlast  output  1  broadcast RLAST, qualified by m_rvalid
m_rdata  output  DATA_WIDTH  broadcast RDATA, qualified by m_rvalid
s_arvalid  output  1  downstream AR valid
s_arready  input  1  downstream AR ready
s_arid  output  4  downstream ARID; zero-extended grant index
s_arlen  output  4  downstream ARLEN
s_araddr  output  ADDR_WIDTH  downstream ARADDR
s_rvalid  input  1  downstream R valid
s_rready  output  1  downstream R ready
s_rlast  input  1  downstream RLAST
s_rid  input  4  downstream RID
s_rdata  input  DATA_WIDTH  downstream RDATA
outstanding_o  output  N_MASTERS*4  per-master in-flight burst count
err_o  output  1  sticky protocol error flag

Behaviour:
Reset (async, rst_n low):
- FSM enters IDLE; grant index = 0; last_grant = N_MASTERS-1, so master 0 wins first.
- All outstanding counters = 0; err_o = 0.
- s_arvalid = 0 and m_arready = 0 during and immediately after reset.
- Reset mid-burst discards all tracking; any R beats still arriving afterwards take the stray-beat rule below.

Eligibility:
- Master i is eligible when m_arvalid[i]=1 and outstanding[i] < MAX_OUTSTANDING.

AR FSM:
- IDLE: if any master is eligible, pick the first eligible index scanning from last_grant+1 with wrap-around, register it as the grant, go to HOLD. Otherwise stay in IDLE.
- HOLD outputs: s_arvalid=1; s_araddr/s_arlen taken combinationally from the granted master's slice; s_arid = grant index.
- HOLD ready: m_arready[grant] = s_arready; all other m_arready = 0. In IDLE all m_arready = 0.
- HOLD exit: on s_arvalid & s_arready, outstanding[grant] += 1, last_grant = grant, return to IDLE.
- HOLD with no handshake: stay in HOLD. A grant is never withdrawn; masters must hold their AR fields stable until the handshake.
- Throughput: at most one AR accepted every 2 cycles. Minimum latency from m_arvalid to s_arvalid is 1 cycle.

R routing (combinational, zero latency):
- Routing index = s_rid[IDX_W-1:0]; an RID is valid when s_rid < N_MASTERS.
- Valid RID: m_rvalid[idx] = s_rvalid; s_rready = m_rready[idx]; all other m_rvalid = 0.
- RLAST handshake (s_rvalid & s_rready & s_rlast) decrements outstanding[idx].
- Invalid RID: s_rready = 1 so the beat is sunk; no m_rvalid is asserted; err_o is set.
- RLAST handshake for a master whose counter is 0: counter stays 0, err_o is set.

Counter rules:
- Increment and decrement of the same counter in the same cycle leave it unchanged.
- Counters never exceed MAX_OUTSTANDING because eligibility gates the grant.
- err_o clears only on reset.

Test Plan:
- Masters 0 and 1 both assert continuously with s_arready=1 -> grants alternate 0,1,0,1; s_arid alternates 0,1; one AR accepted every 2 cycles.
- Master 1 alone, MAX_OUTSTANDING=4, no R traffic -> exactly 4 AR handshakes; outstanding_o[1]=4; m_arready[1] stays 0 afterwards. One RLAST beat with RID=1 -> count drops to 3 and a fifth AR is issued.
- ARLEN=3 burst for master 0 with m_rready[0] toggling 1,0,1,0 -> s_rready mirrors it; 4 data beats delivered in order; counter decrements only on the RLAST handshake.
- s_arready held 0 for 5 cycles while in HOLD, with master 1 also requesting -> grant stays on master 0 and s_araddr is stable; master 1 is granted next.
- R beat with s_rid=5 when N_MASTERS=2 -> s_rready=1; all m_rvalid=0; err_o=1 and stays 1.
- rst_n pulsed low while a master has 2 bursts outstanding and the FSM is in HOLD -> all outputs go to reset values immediately (async); master 0 is granted first afterwards.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// N-master to 1-slave arbiter for the AXI read-address and read-data channels.
// Round-robin AR grants tagged with the master index; R beats are routed back by RID.
module axi_read_arbiter #(
  parameter int unsigned N_MASTERS       = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned IDX_W          = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_MASTERS-1:0]             m_arvalid,
  output logic [N_MASTERS-1:0]             m_arready,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_araddr,
  input  logic [N_MASTERS*4-1:0]           m_arlen,
  output logic [N_MASTERS-1:0]             m_rvalid,
  input  logic [N_MASTERS-1:0]             m_rready,
  output logic                             m_rlast,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             s_arvalid,
  input  logic                             s_arready,
  output logic [3:0]                       s_arid,
  output logic [3:0]                       s_arlen,
  output logic [ADDR_WIDTH-1:0]            s_araddr,
  input  logic                             s_rvalid,
  output logic                             s_rready,
  input  logic                             s_rlast,
  input  logic [3:0]                       s_rid,
  input  logic [DATA_WIDTH-1:0]            s_rdata,
  output logic [N_MASTERS*4-1:0]           outstanding_o,
  output logic                             err_o
);

  typedef enum logic {StIdle, StHold} state_e;

  localparam logic [3:0]           MaxOut     = 4'(MAX_OUTSTANDING);
  localparam logic [3:0]           NumMasters = 4'(N_MASTERS);
  localparam logic [IDX_W-1:0]     LastIdx    = IDX_W'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] OneHot0    = {{(N_MASTERS-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic [IDX_W-1:0]          last_grant_q, last_grant_d;
  logic [N_MASTERS-1:0][3:0] cnt_q, cnt_d;
  logic                      err_q, err_d;

  logic [N_MASTERS-1:0] eligible;
  logic [N_MASTERS-1:0] inc_vec;
  logic [N_MASTERS-1:0] dec_vec;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     cand;
  logic                 ar_hs;
  logic                 rid_ok;
  logic                 rlast_hs;
  logic [IDX_W-1:0]     ridx;

  // A master at its in-flight cap is invisible to the arbiter.
  always_comb begin
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      eligible[i] = m_arvalid[i] && (cnt_q[i] < MaxOut);
    end
  end

  // Scan starts just after the last winner so every master gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= N_MASTERS; k++) begin
      cand = IDX_W'((32'(last_grant_q) + k) % N_MASTERS);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_arvalid    = 1'b0;
    m_arready    = '0;
    ar_hs        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = StHold;
        end
      end
      StHold: begin
        s_arvalid          = 1'b1;
        m_arready[grant_q] = s_arready;
        if (s_arready) begin
          ar_hs        = 1'b1;
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign s_araddr = m_araddr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_arlen  = m_arlen[grant_q*4 +: 4];
  assign s_arid   = 4'(grant_q);

  assign rid_ok   = (s_rid < NumMasters);
  assign ridx     = s_rid[IDX_W-1:0];
  assign m_rdata  = s_rdata;
  assign m_rlast  = s_rlast;

  // Beats with an unknown RID are sunk so the slave cannot stall on them.
  always_comb begin
    m_rvalid = '0;
    s_rready = 1'b1;
    if (rid_ok) begin
      m_rvalid[ridx] = s_rvalid;
      s_rready       = m_rready[ridx];
    end
  end

  assign rlast_hs = s_rvalid & s_rready & s_rlast;
  assign inc_vec  = ar_hs ? (OneHot0 << grant_q) : '0;
  assign dec_vec  = (rlast_hs && rid_ok) ? (OneHot0 << ridx) : '0;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (s_rvalid && !rid_ok) begin
      err_d = 1'b1;
    end
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      // RLAST for a master with nothing in flight is a slave protocol error.
      if (dec_vec[i] && (cnt_q[i] == 4'd0)) begin
        err_d = 1'b1;
      end
      case ({inc_vec[i], dec_vec[i] && (cnt_q[i] != 4'd0)})
        2'b10:   cnt_d[i] = cnt_q[i] + 4'd1;
        2'b01:   cnt_d[i] = cnt_q[i] - 4'd1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= LastIdx;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule
